// File: rtl/ring_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ring_rr_arbiter
//
// Round-robin arbiter that shares one resource among N requesters. Priority is
// held in a one-hot rotating ring register (ptr). From IDLE, the first set
// request found by scanning cyclically upward from the ptr position is granted.
// The grant is held until the owner drops its request, or until the owner has
// held it for MAX_HOLD cycles (MAX_HOLD = 0 disables this limit). On either
// event the grant is dropped for one cycle. The ring then moves to the
// position just past the last owner, so every requester is served in turn.
//
// Ports:
//   clock        in   system clock; all state updates on the rising edge
//   Resetn       in   synchronous active-low reset
//   en           in   arbitration enable; gates new grants only
//   req[N]       in   request vector, bit i = requester i
//   grant[N]     out  one-hot grant (registered), zero when idle
//   grant_valid  out  high whenever grant != 0 (registered)
//   grant_id     out  index of the granted requester, 0 when idle
//   ptr[N]       out  one-hot priority ring; set bit = highest priority
// ----------------------------------------------------------------------------
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; a new grant is issued when en=1 and req!=0
// GRANT | one owner holds the resource; hold_cnt counts held cycles
//
module ring_rr_arbiter #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clock,
    input  logic           Resetn,
    input  logic           en,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic [N-1:0]   ptr
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit HOLD_EN = (MAX_HOLD > 0);
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;

    logic [IDW-1:0]  ptr_idx;
    logic [IDW:0]    scan_pos;
    logic [IDW-1:0]  sel_idx;
    logic [N-1:0]    sel_onehot;
    logic            owner_req;
    logic            timeout;

    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr[i]) begin
                ptr_idx = IDW'(i);
            end
        end
    end

    // Cyclic scan from ptr upward. Walking the offsets from far to near lets
    // the nearest set request overwrite any farther one, so no found flag is
    // needed. One extra bit on scan_pos keeps the wrap subtraction exact.
    always_comb begin
        sel_idx  = '0;
        scan_pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_pos = {1'b0, ptr_idx} + (IDW + 1)'(k);
            if (scan_pos >= (IDW + 1)'(N)) begin
                scan_pos = scan_pos - (IDW + 1)'(N);
            end
            if (req[scan_pos[IDW-1:0]]) begin
                sel_idx = scan_pos[IDW-1:0];
            end
        end
    end

    assign sel_onehot = {{(N-1){1'b0}}, 1'b1} << sel_idx;

    // Only the owner's request bit matters while granted; other bits are
    // ignored so there is no preemption.
    assign owner_req = |(req & grant);
    assign timeout   = HOLD_EN && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clock) begin
        if (!Resetn) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= N'(1);
            hold_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && (|req)) begin
                        state       <= GRANT;
                        grant       <= sel_onehot;
                        grant_valid <= 1'b1;
                        grant_id    <= sel_idx;
                        hold_cnt    <= '0;
                    end
                end
                GRANT: begin
                    // Release and timeout on the same edge collapse into one
                    // handoff; the ring steps exactly once past the owner.
                    if (!owner_req || timeout) begin
                        state       <= IDLE;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_id    <= '0;
                        ptr         <= {grant[N-2:0], grant[N-1]};
                        hold_cnt    <= '0;
                    end else if (HOLD_EN) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
module tb_ring_rr_arbiter;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         Resetn;
    logic         en;
    logic [N-1:0] req;

    logic [N-1:0] g_a, p_a, g_b, p_b;
    logic         v_a, v_b;
    logic [1:0]   id_a, id_b;

    int vectors = 0;
    int errors  = 0;

    // reference model state, index 0 = MAX_HOLD 8 instance, 1 = MAX_HOLD 0
    int m_owner [2];
    int m_ptr   [2];
    int m_len   [2];

    always #5 clock = ~clock;

    ring_rr_arbiter #(.N(N), .MAX_HOLD(8)) dut_a (
        .clock(clock), .Resetn(Resetn), .en(en), .req(req),
        .grant(g_a), .grant_valid(v_a), .grant_id(id_a), .ptr(p_a)
    );

    ring_rr_arbiter #(.N(N), .MAX_HOLD(0)) dut_b (
        .clock(clock), .Resetn(Resetn), .en(en), .req(req),
        .grant(g_b), .grant_valid(v_b), .grant_id(id_b), .ptr(p_b)
    );

    function automatic int maxh(int d);
        return (d == 0) ? 8 : 0;
    endfunction

    // Behavioural rules: ring position as an integer, owner as an integer
    // (-1 = none), len = cycles the current grant has been visible.
    function automatic void model_step(int d);
        bit found;
        int j;
        if (!Resetn) begin
            m_owner[d] = -1;
            m_ptr[d]   = 0;
            m_len[d]   = 0;
        end else if (m_owner[d] < 0) begin
            if (en && req != 0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr[d] + k) % N;
                    if (!found && req[j]) begin
                        found      = 1;
                        m_owner[d] = j;
                        m_len[d]   = 1;
                    end
                end
            end
        end else if (!req[m_owner[d]] || (maxh(d) != 0 && m_len[d] == maxh(d))) begin
            m_ptr[d]   = (m_owner[d] + 1) % N;
            m_owner[d] = -1;
            m_len[d]   = 0;
        end else begin
            m_len[d]++;
        end
    endfunction

    function automatic logic [10:0] exp_vec(int d);
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic [1:0]   id;
        g  = (m_owner[d] < 0) ? '0 : (N'(1) << m_owner[d]);
        id = (m_owner[d] < 0) ? 2'd0 : 2'(m_owner[d]);
        p  = N'(1) << m_ptr[d];
        return {g, (m_owner[d] >= 0), id, p};
    endfunction

    function automatic logic [10:0] obs(int d);
        return (d == 0) ? {g_a, v_a, id_a, p_a} : {g_b, v_b, id_b, p_b};
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        en     = 1'b1;
        req    = 4'b1111;
        tick();
        vectors++;
        if ({g_a, v_a, id_a, p_a} !== {4'b0000, 1'b0, 2'd0, 4'b0001}) begin
            errors++;
            $display("FAIL reset_state got g=%b v=%b id=%0d p=%b exp g=0000 v=0 id=0 p=0001",
                     g_a, v_a, id_a, p_a);
        end
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (obs(d) !== exp_vec(d)) begin
                errors++;
                $display("FAIL reset_model dut%0d got=%h exp=%h", d, obs(d), exp_vec(d));
            end
        end
        Resetn = 1'b1;
    endtask

    task automatic test_basic();
        logic [N-1:0] exp_g [3];
        logic [N-1:0] exp_p [3];
        logic [N-1:0] req_s [3];
        exp_g = '{4'b0010, 4'b0000, 4'b1000};
        exp_p = '{4'b0001, 4'b0100, 4'b0100};
        req_s = '{4'b1010, 4'b1000, 4'b1000};
        do_reset();
        en = 1'b1;
        for (int s = 0; s < 3; s++) begin
            req = req_s[s];
            tick();
            vectors++;
            if (g_a !== exp_g[s] || p_a !== exp_p[s]) begin
                errors++;
                $display("FAIL basic_step%0d got g=%b p=%b exp g=%b p=%b",
                         s, g_a, p_a, exp_g[s], exp_p[s]);
            end
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL basic_model%0d dut%0d got=%h exp=%h", s, d, obs(d), exp_vec(d));
                end
            end
        end
        vectors++;
        if (id_a !== 2'd3) begin
            errors++;
            $display("FAIL basic_id got=%0d exp=3", id_a);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_g;
        do_reset();
        en  = 1'b1;
        req = 4'b1111;
        for (int t = 0; t < 45; t++) begin
            tick();
            // 8 granted cycles then one idle cycle, owner advancing 0,1,2,3,0
            exp_g = ((t % 9) < 8) ? N'(1 << ((t / 9) % N)) : '0;
            vectors++;
            if (g_a !== exp_g) begin
                errors++;
                $display("FAIL fairness_t%0d got g=%b exp g=%b", t, g_a, exp_g);
            end
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL fairness_model t%0d dut%0d got=%h exp=%h", t, d, obs(d), exp_vec(d));
                end
            end
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_enable();
        do_reset();
        en  = 1'b0;
        req = 4'b0100;
        for (int t = 0; t < 5; t++) begin
            tick();
            vectors++;
            if (g_a !== 4'b0000) begin
                errors++;
                $display("FAIL enable_gated_t%0d got g=%b exp g=0000", t, g_a);
            end
        end
        en = 1'b1;
        tick();
        vectors++;
        if (g_a !== 4'b0100 || id_a !== 2'd2) begin
            errors++;
            $display("FAIL enable_grant got g=%b id=%0d exp g=0100 id=2", g_a, id_a);
        end
        en = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            vectors++;
            if (g_a !== 4'b0100) begin
                errors++;
                $display("FAIL enable_hold_t%0d got g=%b exp g=0100", t, g_a);
            end
        end
        req = 4'b0000;
        tick();
        vectors++;
        if (g_a !== 4'b0000 || p_a !== 4'b1000) begin
            errors++;
            $display("FAIL enable_release got g=%b p=%b exp g=0000 p=1000", g_a, p_a);
        end
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (obs(d) !== exp_vec(d)) begin
                errors++;
                $display("FAIL enable_model dut%0d got=%h exp=%h", d, obs(d), exp_vec(d));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en  = 1'b1;
        req = 4'b0100;
        tick();
        vectors++;
        if (g_a !== 4'b0100) begin
            errors++;
            $display("FAIL midreset_pre got g=%b exp g=0100", g_a);
        end
        Resetn = 1'b0;
        tick();
        vectors++;
        if (g_a !== 4'b0000 || p_a !== 4'b0001 || v_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear got g=%b p=%b v=%b exp g=0000 p=0001 v=0", g_a, p_a, v_a);
        end
        Resetn = 1'b1;
        tick();
        vectors++;
        if (g_a !== 4'b0100 || id_a !== 2'd2) begin
            errors++;
            $display("FAIL midreset_regrant got g=%b id=%0d exp g=0100 id=2", g_a, id_a);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_no_timeout();
        do_reset();
        en  = 1'b1;
        req = 4'b1001;
        for (int t = 0; t < 50; t++) begin
            tick();
            vectors++;
            if (g_b !== 4'b0001 || p_b !== 4'b0001) begin
                errors++;
                $display("FAIL notimeout_t%0d got g=%b p=%b exp g=0001 p=0001", t, g_b, p_b);
            end
            vectors++;
            if (obs(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL notimeout_model_a t%0d got=%h exp=%h", t, obs(0), exp_vec(0));
            end
        end
        req = 4'b1000;
        tick();
        vectors++;
        if (g_b !== 4'b0000 || p_b !== 4'b0010) begin
            errors++;
            $display("FAIL notimeout_release got g=%b p=%b exp g=0000 p=0010", g_b, p_b);
        end
        tick();
        vectors++;
        if (g_b !== 4'b1000 || id_b !== 2'd3) begin
            errors++;
            $display("FAIL notimeout_next got g=%b id=%0d exp g=1000 id=3", g_b, id_b);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            en     = ($urandom_range(0, 9) != 0);
            Resetn = ($urandom_range(0, 99) != 0);
            tick();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL random_c%0d dut%0d got=%h exp=%h", c, d, obs(d), exp_vec(d));
                end
            end
        end
        Resetn = 1'b1;
    endtask

    initial begin
        Resetn = 1'b0;
        en     = 1'b0;
        req    = '0;
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_ptr[d]   = 0;
            m_len[d]   = 0;
        end
        test_reset();
        test_basic();
        test_fairness();
        test_enable();
        test_reset_mid();
        test_no_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
